// File: rtl/instruction_loader.sv
// Purpose : loads instruction memory from a UART byte stream (count byte, big-endian
//           data words, XOR checksum byte) into sequential word addresses from 0.
// Latency : write pulse one cycle after the 4th byte of a word; done/error one cycle after the checksum.
// Backpressure: none; a byte may arrive every cycle and none are dropped in LOAD or CHECK.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               one-cycle pulse, arms a new load (ignored while busy)
//   rx_valid, rx_data   received byte strobe and value
//   we, wa, wd          instruction memory write port (we is a one-cycle pulse)
//   busy, done, error   load status
module instruction_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wa,
    output logic [31:0]           wd,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Word counter needs one extra bit so it can reach N = DEPTH without wrapping.
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_COUNT,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [31:0]           wd_q, wd_d;
    logic [23:0]           shift_q, shift_d;     // first three bytes of the current word
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [CW-1:0]         word_cnt_q, word_cnt_d;
    logic [CW-1:0]         n_words_q, n_words_d;
    logic [7:0]            csum_q, csum_d;

    logic                  count_legal;
    logic [CW-1:0]         count_words;

    // Count byte 0x00 encodes a full memory; anything above DEPTH is illegal.
    assign count_legal = ({24'd0, rx_data} <= 32'(DEPTH));
    assign count_words = (rx_data == 8'd0) ? DEPTH_C : CW'(rx_data);

    always_comb begin
        state_d    = state_q;
        we_d       = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        n_words_d  = n_words_q;
        csum_d     = csum_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WAIT_COUNT;
            end
            S_WAIT_COUNT: begin
                if (rx_valid) begin
                    if (count_legal) begin
                        state_d    = S_LOAD;
                        n_words_d  = count_words;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        csum_d     = '0;
                        shift_d    = '0;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_LOAD: begin
                if (rx_valid) begin
                    shift_d    = {shift_q[15:0], rx_data};
                    csum_d     = csum_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        wa_d       = word_cnt_q[ADDR_WIDTH-1:0];
                        wd_d       = {shift_q, rx_data};
                        word_cnt_d = word_cnt_q + CW'(1);
                        if (word_cnt_q + CW'(1) == n_words_q) state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (rx_valid) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (start) state_d = S_WAIT_COUNT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            n_words_q  <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            n_words_q  <= n_words_d;
            csum_q     <= csum_d;
        end
    end

    assign we    = we_q;
    assign wa    = wa_q;
    assign wd    = wd_q;
    assign busy  = (state_q == S_WAIT_COUNT) || (state_q == S_LOAD) || (state_q == S_CHECK);
    assign done  = (state_q == S_DONE);
    assign error = (state_q == S_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Purpose : directed self-checking bench for instruction_loader.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: none; writes are logged on the falling edge.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [5:0]  log_wa[$];
    logic [31:0] log_wd[$];

    instruction_loader #(.ADDR_WIDTH(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            log_wa.push_back(wa);
            log_wd.push_back(wd);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_wa.delete();
        log_wd.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        tick();
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    {31'd0, we},    32'd0);
        check({tag, "_wa"},    {26'd0, wa},    32'd0);
        check({tag, "_wd"},    wd,             32'd0);
        check({tag, "_busy"},  {31'd0, busy},  32'd0);
        check({tag, "_done"},  {31'd0, done},  32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    // Two-word frame, bytes gapped 3 cycles apart, with write checks at each word boundary.
    task automatic run_frame2(input string tag, input logic [7:0] cs);
        logic [7:0] bytes [8];
        bytes = '{8'h28, 8'h02, 8'h00, 8'h05, 8'h28, 8'h03, 8'h00, 8'h0C};
        clear_log();
        pulse_start();
        check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        send_gap(8'h02);
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i]);
            if (i == 3) begin
                check({tag, "_w0_we"}, {31'd0, we}, 32'd1);
                check({tag, "_w0_wa"}, {26'd0, wa}, 32'd0);
                check({tag, "_w0_wd"}, wd, 32'h28020005);
            end
            if (i == 7) begin
                check({tag, "_w1_we"}, {31'd0, we}, 32'd1);
                check({tag, "_w1_wa"}, {26'd0, wa}, 32'd1);
                check({tag, "_w1_wd"}, wd, 32'h2803000C);
            end
            tick();
            check({tag, "_we_single_pulse"}, {31'd0, we}, 32'd0);
            tick();
        end
        send_byte(cs);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_nwrites"}, log_wa.size(), 32'd2);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs("reset");

        // Good two-word load.
        run_frame2("good", 8'h08);
        check("good_done",  {31'd0, done},  32'd1);
        check("good_error", {31'd0, error}, 32'd0);

        // Same frame, wrong checksum: writes still happen, error raised.
        run_frame2("badcs", 8'h09);
        check("badcs_done",  {31'd0, done},  32'd0);
        check("badcs_error", {31'd0, error}, 32'd1);

        // Illegal count byte.
        clear_log();
        pulse_start();
        send_byte(8'h41);
        check("illegal_error", {31'd0, error}, 32'd1);
        check("illegal_busy",  {31'd0, busy},  32'd0);
        check("illegal_we",    {31'd0, we},    32'd0);
        tick();
        check("illegal_nwrites", log_wa.size(), 32'd0);
        pulse_start();
        check("restart_error", {31'd0, error}, 32'd0);
        check("restart_busy",  {31'd0, busy},  32'd1);

        // Full 64-word load back-to-back, count byte 0x00 (already in WAIT_COUNT).
        clear_log();
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        tick();
        for (int i = 0; i < 256; i++) begin
            rx_data = 8'(i);
            tick();
        end
        rx_data = 8'h00;   // XOR of 0..255 is 0
        tick();
        rx_valid = 1'b0;
        check("full_done", {31'd0, done}, 32'd1);
        check("full_busy", {31'd0, busy}, 32'd0);
        check("full_nwrites", log_wa.size(), 32'd64);
        if (log_wa.size() == 64) begin
            for (int w = 0; w < 64; w++) begin
                logic [7:0] b0, b1, b2, b3;
                b0 = 8'(4 * w);
                b1 = 8'(4 * w + 1);
                b2 = 8'(4 * w + 2);
                b3 = 8'(4 * w + 3);
                check($sformatf("full_wa%0d", w), {26'd0, log_wa[w]}, 32'(w));
                check($sformatf("full_wd%0d", w), log_wd[w], {b0, b1, b2, b3});
            end
        end
        check("full_final_wa", {26'd0, wa}, 32'd63);

        // Reset mid-word during a 3-word load.
        clear_log();
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("midreset");
        check("midreset_nwrites", log_wa.size(), 32'd1);
        if (log_wa.size() >= 1) check("midreset_wa0", {26'd0, log_wa[0]}, 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h77);
        tick();
        check("midreset_nowrite_after", log_wa.size(), 32'd1);
        check("midreset_idle_busy", {31'd0, busy}, 32'd0);

        // Start coincident with a byte in IDLE, then start mid-load.
        clear_log();
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h05;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        check("coinc_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h01);
        send_byte(8'hA1);
        send_byte(8'hB2);
        pulse_start();
        check("midstart_busy", {31'd0, busy}, 32'd1);
        send_byte(8'hC3);
        send_byte(8'hD4);
        check("coinc_we", {31'd0, we}, 32'd1);
        check("coinc_wd", wd, 32'hA1B2C3D4);
        send_byte(8'h04);
        check("coinc_done",  {31'd0, done},  32'd1);
        check("coinc_error", {31'd0, error}, 32'd0);
        check("coinc_nwrites", log_wa.size(), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Program loader that writes instruction memory from a byte stream: it is the write-side counterpart to the single-read-port instruction memory. It sits between a UART byte receiver and the instruction memory write port. It assembles big-endian 32-bit words, writes them to sequential word addresses starting at 0, and verifies an XOR checksum. It holds `busy` high while loading so the processor can be kept in reset.

## Interface
Parameters:
- ADDR_WIDTH, 6, word-address width; depth = 2**ADDR_WIDTH (64 words).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; arms a new load.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte.
- we  out  1  instruction memory write enable, one-cycle pulse per word.
- wa  out  ADDR_WIDTH  word write address.
- wd  out  32  write data word.
- busy  out  1  high while a load is in progress.
- done  out  1  high after a successful load, until the next accepted start or reset.
- error  out  1  high after a failed load, until the next accepted start or reset.

## Operation
- The frame format is: count byte C, then 4·N data bytes (MSB first per word), then one checksum byte.
  - N = 64 when C = 0x00.
  - N = C when 1 ≤ C ≤ 64.
  - C > 64 is illegal.
- Checksum = XOR of all 4·N data bytes. The count byte is excluded.
- State machine:
  - IDLE: start → WAIT_COUNT. Bytes are ignored.
  - WAIT_COUNT: on rx_valid:
    - C legal → LOAD, with word counter 0, byte counter 0, checksum 0.
    - C illegal → ERROR.
  - LOAD: each rx_valid shifts the byte into the word shift register and XORs it into the checksum.
    - On the 4th byte of a word, issue a write with wa = word index and wd = the assembled word, then increment the word index.
    - After the write of word N−1 → CHECK.
  - CHECK: on rx_valid:
    - byte == checksum → DONE.
    - otherwise → ERROR.
  - DONE / ERROR: start → WAIT_COUNT, which clears done/error. Bytes are ignored.
- Outputs:
  - busy = (state ∈ {WAIT_COUNT, LOAD, CHECK}).
  - done = (state == DONE).
  - error = (state == ERROR).
- start while busy is ignored. It does not restart the load.
- Words already written are never rolled back on error, abort or reset.
- Address wrap is impossible: the word index saturates at N and the FSM leaves LOAD.

## Timing
- Reset values:
  - state IDLE.
  - we=0, wa=0, wd=0x00000000, busy=0, done=0, error=0.
  - internal counters and checksum 0.
- start in cycle t → busy=1 in cycle t+1. An rx_valid in cycle t itself is ignored.
- Write latency: 4th byte strobed in cycle t → we=1, with wa/wd valid, in cycle t+1 only.
  - wa/wd hold their values until the next write.
- Throughput: rx_valid may be asserted every cycle. No byte is dropped in LOAD or CHECK.
  - A write pulse may coincide with acceptance of the next word's first byte.
- Checksum byte in cycle t → done or error = 1 and busy = 0 in cycle t+1.
- Illegal count byte in cycle t → error=1, busy=0 in cycle t+1, with no write.
- reset in any cycle, including mid-word, overrides everything. The next cycle shows reset values, and any partially assembled word is discarded (no write).

## Test plan
- 2-word load: start, then bytes 02 28 02 00 05 28 03 00 0C 08, gapped 3 cycles apart.
  - Writes: wa=0 wd=0x28020005, then wa=1 wd=0x2803000C.
  - done=1, error=0, busy=0.
- Same frame with checksum byte 09 → both writes still occur, then error=1, done=0.
- Count 0x41 → error=1 one cycle later, we never asserted. A subsequent start clears error and raises busy.
- Count 0x00 with 256 data bytes back-to-back (rx_valid every cycle) plus correct checksum:
  - exactly 64 we pulses, wa 0..63 in order, final wa=63.
  - done=1.
- Reset asserted after 2 bytes of word 1 in a 3-word load:
  - only the wa=0 write occurred.
  - all outputs are at reset values next cycle.
  - a further rx_valid produces no write until start.
- start pulsed mid-LOAD and start coincident with rx_valid in IDLE:
  - the load continues unaffected.
  - the coincident byte is ignored and the next byte is taken as the count.
